// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands and op in, result halves and flags out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_hi;
  logic             cout;
  logic             borrow;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, c_hi, cout, borrow, zero, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, c_hi, cout, borrow, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift, WIDTH-cycle shift-add multiply,
// result held in DONE until the consumer takes it.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_c_hi;
  logic             r_cout;
  logic             r_borrow;
  logic             r_zero;
  logic             r_err;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_mul_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_c;
  logic             w_cout;
  logic             w_borrow;
  logic             w_err;

  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_mul_last = (r_cnt == CNT_W'(WIDTH));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = (bus.op == OP_MUL) ? MUL : DONE;
      MUL:     if (w_mul_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single-cycle result for every op except multiply; unknown op flags err
  always_comb begin
    w_sum    = {1'b0, bus.a} + {1'b0, bus.b};
    w_c      = '0;
    w_cout   = 1'b0;
    w_borrow = 1'b0;
    w_err    = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_c    = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_c      = bus.a - bus.b;
        w_borrow = (bus.a < bus.b);
      end
      OP_XOR: w_c = bus.a ^ bus.b;
      OP_SHL: begin
        w_c    = {bus.a[WIDTH-2:0], 1'b0};
        w_cout = bus.a[WIDTH-1];
      end
      OP_AND:  w_c = bus.a & bus.b;
      OP_OR:   w_c = bus.a | bus.b;
      OP_MUL:  w_c = '0;
      default: w_err = 1'b1;
    endcase
  end

  // State and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Result registers and multiply datapath; results only move on accept or multiply completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c      <= '0;
      r_c_hi   <= '0;
      r_cout   <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (bus.op == OP_MUL) begin
        r_mcand  <= {{WIDTH{1'b0}}, bus.a};
        r_mplier <= bus.b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_c      <= w_c;
        r_c_hi   <= '0;
        r_cout   <= w_cout;
        r_borrow <= w_borrow;
        r_err    <= w_err;
        r_zero   <= (w_c == '0);
      end
    end else if (r_state == MUL) begin
      if (!w_mul_last) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end else begin
        r_c      <= r_acc[WIDTH-1:0];
        r_c_hi   <= r_acc[PW-1:WIDTH];
        r_cout   <= |r_acc[PW-1:WIDTH];
        r_borrow <= 1'b0;
        r_err    <= 1'b0;
        r_zero   <= (r_acc == '0);
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;
  assign bus.c_hi      = r_c_hi;
  assign bus.cout      = r_cout;
  assign bus.borrow    = r_borrow;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 8-bit instance for arithmetic/handshake/reset, 16-bit for shift/reserved/mul.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8  ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Flags packed as {cout, borrow, zero, err}
  logic [3:0] f8;
  logic [3:0] f16;
  assign f8  = {bus8.cout, bus8.borrow, bus8.zero, bus8.err};
  assign f16 = {bus16.cout, bus16.borrow, bus16.zero, bus16.err};

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.op = op; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic consume8;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus16.op = op; bus16.a = a; bus16.b = b; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic consume16;
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #2;
    checks++; if ({bus8.out_valid, bus8.c, bus8.c_hi, f8} !== {1'b0, 8'd0, 8'd0, 4'b0000}) begin
      errors++; $display("FAIL reset8: got v=%b c=%0d chi=%0d f=%b want v=0 c=0 chi=0 f=0000", bus8.out_valid, bus8.c, bus8.c_hi, f8);
    end
    checks++; if ({bus16.out_valid, bus16.c, bus16.c_hi, f16} !== {1'b0, 16'd0, 16'd0, 4'b0000}) begin
      errors++; $display("FAIL reset16: got v=%b c=%0d chi=%0d f=%b want all zero", bus16.out_valid, bus16.c, bus16.c_hi, f16);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({bus8.in_ready, bus16.in_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b%b want 11", bus8.in_ready, bus16.in_ready);
    end
  endtask

  task automatic test_add;
    issue8(OP_ADD, 8'd200, 8'd100);
    checks++; if ({bus8.out_valid, bus8.c, bus8.c_hi, f8} !== {1'b1, 8'd44, 8'd0, 4'b1000}) begin
      errors++; $display("FAIL add: got v=%b c=%0d chi=%0d f=%b want v=1 c=44 chi=0 f=1000", bus8.out_valid, bus8.c, bus8.c_hi, f8);
    end
    consume8();
    checks++; if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
      errors++; $display("FAIL add_release: got v=%b rdy=%b want v=0 rdy=1", bus8.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_sub;
    issue8(OP_SUB, 8'd5, 8'd7);
    checks++; if ({bus8.out_valid, bus8.c, f8} !== {1'b1, 8'd254, 4'b0100}) begin
      errors++; $display("FAIL sub_neg: got v=%b c=%0d f=%b want v=1 c=254 f=0100", bus8.out_valid, bus8.c, f8);
    end
    consume8();
    issue8(OP_SUB, 8'd7, 8'd7);
    checks++; if ({bus8.out_valid, bus8.c, bus8.c_hi, f8} !== {1'b1, 8'd0, 8'd0, 4'b0010}) begin
      errors++; $display("FAIL sub_zero: got v=%b c=%0d chi=%0d f=%b want v=1 c=0 chi=0 f=0010", bus8.out_valid, bus8.c, bus8.c_hi, f8);
    end
    consume8();
  endtask

  task automatic test_logic;
    logic [2:0] t_op [5];
    logic [7:0] t_a  [5];
    logic [7:0] t_b  [5];
    logic [7:0] t_c  [5];
    logic [3:0] t_f  [5];
    t_op[0] = OP_XOR; t_a[0] = 8'hF0; t_b[0] = 8'h3C; t_c[0] = 8'hCC; t_f[0] = 4'b0000;
    t_op[1] = OP_AND; t_a[1] = 8'hF0; t_b[1] = 8'h3C; t_c[1] = 8'h30; t_f[1] = 4'b0000;
    t_op[2] = OP_OR;  t_a[2] = 8'hF0; t_b[2] = 8'h3C; t_c[2] = 8'hFC; t_f[2] = 4'b0000;
    t_op[3] = OP_SHL; t_a[3] = 8'h81; t_b[3] = 8'hFF; t_c[3] = 8'h02; t_f[3] = 4'b1000;
    t_op[4] = OP_AND; t_a[4] = 8'h0F; t_b[4] = 8'hF0; t_c[4] = 8'h00; t_f[4] = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      issue8(t_op[i], t_a[i], t_b[i]);
      checks++; if ({bus8.out_valid, bus8.c, bus8.c_hi, f8} !== {1'b1, t_c[i], 8'd0, t_f[i]}) begin
        errors++; $display("FAIL logic[%0d]: got v=%b c=%h chi=%h f=%b want v=1 c=%h chi=00 f=%b", i, bus8.out_valid, bus8.c, bus8.c_hi, f8, t_c[i], t_f[i]);
      end
      consume8();
    end
  endtask

  task automatic test_mul;
    issue8(OP_MUL, 8'd255, 8'd255);
    // Requests arriving mid-multiply must be ignored
    bus8.in_valid = 1'b1; bus8.op = OP_ADD; bus8.a = 8'd1; bus8.b = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      bus8.a = 8'(k);
      checks++; if ({bus8.out_valid, bus8.in_ready} !== 2'b00) begin
        errors++; $display("FAIL mul_busy[%0d]: got v=%b rdy=%b want v=0 rdy=0", k, bus8.out_valid, bus8.in_ready);
      end
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    checks++; if ({bus8.out_valid, bus8.in_ready, bus8.c_hi, bus8.c, f8} !== {1'b1, 1'b0, 8'd254, 8'd1, 4'b1000}) begin
      errors++; $display("FAIL mul_255: got v=%b rdy=%b chi=%0d c=%0d f=%b want v=1 rdy=0 chi=254 c=1 f=1000", bus8.out_valid, bus8.in_ready, bus8.c_hi, bus8.c, f8);
    end
    consume8();
    issue8(OP_MUL, 8'd13, 8'd11);
    repeat (9) @(posedge clk);
    #1;
    checks++; if ({bus8.out_valid, bus8.c_hi, bus8.c, f8} !== {1'b1, 8'd0, 8'd143, 4'b0000}) begin
      errors++; $display("FAIL mul_13x11: got v=%b chi=%0d c=%0d f=%b want v=1 chi=0 c=143 f=0000", bus8.out_valid, bus8.c_hi, bus8.c, f8);
    end
    consume8();
    issue8(OP_MUL, 8'h5A, 8'd0);
    repeat (9) @(posedge clk);
    #1;
    checks++; if ({bus8.out_valid, bus8.c_hi, bus8.c, f8} !== {1'b1, 8'd0, 8'd0, 4'b0010}) begin
      errors++; $display("FAIL mul_zero: got v=%b chi=%0d c=%0d f=%b want v=1 chi=0 c=0 f=0010", bus8.out_valid, bus8.c_hi, bus8.c, f8);
    end
    consume8();
  endtask

  task automatic test_backpressure;
    issue8(OP_ADD, 8'd3, 8'd4);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1; bus8.op = 3'(i); bus8.a = 8'(i * 17 + 1); bus8.b = 8'(i * 5 + 2);
      @(posedge clk); #1;
      checks++; if ({bus8.out_valid, bus8.in_ready, bus8.c, f8} !== {1'b1, 1'b0, 8'd7, 4'b0000}) begin
        errors++; $display("FAIL hold[%0d]: got v=%b rdy=%b c=%0d f=%b want v=1 rdy=0 c=7 f=0000", i, bus8.out_valid, bus8.in_ready, bus8.c, f8);
      end
    end
    bus8.op = OP_ADD; bus8.a = 8'd9; bus8.b = 8'd9;
    consume8();
    checks++; if ({bus8.out_valid, bus8.in_ready, bus8.c} !== {1'b0, 1'b1, 8'd7}) begin
      errors++; $display("FAIL release: got v=%b rdy=%b c=%0d want v=0 rdy=1 c=7", bus8.out_valid, bus8.in_ready, bus8.c);
    end
  endtask

  task automatic test_back_to_back;
    // in_valid is still high from the backpressure scenario, so this edge accepts 9+9
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    checks++; if ({bus8.out_valid, bus8.c, f8} !== {1'b1, 8'd18, 4'b0000}) begin
      errors++; $display("FAIL b2b_add: got v=%b c=%0d f=%b want v=1 c=18 f=0000", bus8.out_valid, bus8.c, f8);
    end
    consume8();
    issue8(OP_SUB, 8'd10, 8'd3);
    checks++; if ({bus8.out_valid, bus8.c, f8} !== {1'b1, 8'd7, 4'b0000}) begin
      errors++; $display("FAIL b2b_sub: got v=%b c=%0d f=%b want v=1 c=7 f=0000", bus8.out_valid, bus8.c, f8);
    end
    consume8();
  endtask

  task automatic test_reset_mid_mul;
    logic seen;
    issue8(OP_MUL, 8'd255, 8'd255);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus8.out_valid, bus8.c, bus8.c_hi, f8} !== {1'b0, 8'd0, 8'd0, 4'b0000}) begin
      errors++; $display("FAIL rst_async: got v=%b c=%0d chi=%0d f=%b want v=0 c=0 chi=0 f=0000", bus8.out_valid, bus8.c, bus8.c_hi, f8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
      errors++; $display("FAIL rst_ready: got v=%b rdy=%b want v=0 rdy=1", bus8.out_valid, bus8.in_ready);
    end
    issue8(OP_ADD, 8'd1, 8'd1);
    checks++; if ({bus8.out_valid, bus8.c, bus8.c_hi, f8} !== {1'b1, 8'd2, 8'd0, 4'b0000}) begin
      errors++; $display("FAIL rst_add: got v=%b c=%0d chi=%0d f=%b want v=1 c=2 chi=0 f=0000", bus8.out_valid, bus8.c, bus8.c_hi, f8);
    end
    consume8();
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus8.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_stale: got out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_w16;
    logic seen;
    issue16(OP_SHL, 16'h8001, 16'h0000);
    checks++; if ({bus16.out_valid, bus16.c, bus16.c_hi, f16} !== {1'b1, 16'h0002, 16'h0000, 4'b1000}) begin
      errors++; $display("FAIL w16_shl: got v=%b c=%h chi=%h f=%b want v=1 c=0002 chi=0000 f=1000", bus16.out_valid, bus16.c, bus16.c_hi, f16);
    end
    consume16();
    issue16(OP_RSV, 16'h1234, 16'h5678);
    checks++; if ({bus16.out_valid, bus16.c, bus16.c_hi, f16} !== {1'b1, 16'h0000, 16'h0000, 4'b0011}) begin
      errors++; $display("FAIL w16_rsv: got v=%b c=%h chi=%h f=%b want v=1 c=0000 chi=0000 f=0011", bus16.out_valid, bus16.c, bus16.c_hi, f16);
    end
    consume16();
    issue16(OP_MUL, 16'hFFFF, 16'hFFFF);
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (bus16.out_valid || bus16.in_ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin
      errors++; $display("FAIL w16_mul_busy: got early valid/ready=%b want 0", seen);
    end
    @(posedge clk); #1;
    checks++; if ({bus16.out_valid, bus16.c_hi, bus16.c, f16} !== {1'b1, 16'hFFFE, 16'h0001, 4'b1000}) begin
      errors++; $display("FAIL w16_mul: got v=%b chi=%h c=%h f=%b want v=1 chi=fffe c=0001 f=1000", bus16.out_valid, bus16.c_hi, bus16.c, f16);
    end
    consume16();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.op  = OP_ADD; bus8.out_ready  = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.op = OP_ADD; bus16.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
